// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter and its bench.
//   state_e  : FSM state encoding (IDLE=0, GRANT=1)
//   NUM_REQ  : number of requesters (4)
//   CNT_W    : beat counter width (4 bits, enough for bursts of up to 16)
//   rr_pick  : round-robin search helper
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns the first set request bit searching last+1, last+2, last+3, last
  // (mod 4). The loop runs from the farthest offset to the nearest so that
  // the nearest set bit is the one left in pick. If no bit is set the result
  // is meaningless; callers only use it when req != 0.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                         input logic [1:0]         last);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = last + 2'(i);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_mux4to1.sv
// Mux4to1: 4-input word multiplexer, purely combinational.
//   Data0..Data3 : input words, WORD_LENGTH bits
//   Sel          : binary select
//   Out          : Data[Sel]
module Mux4to1 #(
  parameter int WORD_LENGTH = 8
) (
  input  logic [WORD_LENGTH-1:0] Data0,
  input  logic [WORD_LENGTH-1:0] Data1,
  input  logic [WORD_LENGTH-1:0] Data2,
  input  logic [WORD_LENGTH-1:0] Data3,
  input  logic [1:0]             Sel,
  output logic [WORD_LENGTH-1:0] Out
);

  always_comb begin
    Out = Data0;
    case (Sel)
      2'd0:    Out = Data0;
      2'd1:    Out = Data1;
      2'd2:    Out = Data2;
      default: Out = Data3;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter for four requesters feeding a single
// downstream port, with bursts of up to MAX_BURST beats per grant.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   Req[3:0]          : per-requester request
//   Data0..Data3      : requester payloads
//   Out_Ready         : downstream accepts a beat
//   Grant[3:0]        : one-hot grant, zero in IDLE
//   Selector[1:0]     : index of the current / last granted requester
//   Out_Valid         : Out_Data holds a valid beat
//   Out_Data          : Data[Selector], combinational
//   Burst_Done        : one-cycle pulse in the cycle a grant is released
//   dbg_state         : current FSM state, for observation only
//
// Handshake: a beat moves on every rising edge where Out_Valid && Out_Ready
// are both high. Out_Valid never depends on Out_Ready. The granted requester
// sees Grant[i] && Out_Ready as acceptance of its current word.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter int MAX_BURST   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [WORD_LENGTH-1:0] Data0,
  input  logic [WORD_LENGTH-1:0] Data1,
  input  logic [WORD_LENGTH-1:0] Data2,
  input  logic [WORD_LENGTH-1:0] Data3,
  input  logic                   Out_Ready,
  output logic [NUM_REQ-1:0]     Grant,
  output logic [1:0]             Selector,
  output logic                   Out_Valid,
  output logic [WORD_LENGTH-1:0] Out_Data,
  output logic                   Burst_Done,
  output state_e                 dbg_state
);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req_sel;
  logic xfer;
  logic rel_grant;

  always_comb begin
    req_sel   = Req[sel_q];
    Out_Valid = (state_q == GRANT) && req_sel;
    xfer      = Out_Valid && Out_Ready;
    // Release on the final beat of the burst or when the owner withdraws.
    // Both cannot hold at once because a transfer needs Req[sel] high.
    rel_grant = (state_q == GRANT) && ((xfer && (cnt_q == LAST_BEAT)) || !req_sel);
    // A reset edge abandons the burst silently.
    Burst_Done = rel_grant && !reset;
    Grant      = (state_q == GRANT) ? (NUM_REQ'(1) << sel_q) : '0;
    Selector   = sel_q;
    dbg_state  = state_q;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|Req) begin
          sel_d   = rr_pick(Req, last_q);
          last_d  = sel_d;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (rel_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  Mux4to1 #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_mux (
    .Data0 (Data0),
    .Data1 (Data1),
    .Data2 (Data2),
    .Data3 (Data3),
    .Sel   (sel_q),
    .Out   (Out_Data)
  );

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The module SHALL have parameter WORD_LENGTH, default 8, giving the data width of every data port.
REQ-002 The module SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant; legal range 1..16.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port Req, input, 4 bits: per-requester request; bit i belongs to requester i.
REQ-006 The module SHALL have ports Data0..Data3, input, WORD_LENGTH bits each: requester payloads.
REQ-007 The module SHALL have port Out_Ready, input, 1 bit: downstream accepts a beat.
REQ-008 The module SHALL have port Grant, output, 4 bits: one-hot grant, all-zero when idle.
REQ-009 The module SHALL have port Selector, output, 2 bits: binary index of the current or last granted requester.
REQ-010 The module SHALL have port Out_Valid, output, 1 bit: Out_Data holds a valid beat.
REQ-011 The module SHALL have port Out_Data, output, WORD_LENGTH bits: payload of the granted requester.
REQ-012 The module SHALL have port Burst_Done, output, 1 bit: one-cycle pulse on the cycle a grant is released.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and GRANT; Grant is non-zero only in GRANT.
REQ-014 In IDLE with Req != 0, the module SHALL pick the first set Req bit searching Last+1, Last+2, Last+3, Last (mod 4). It SHALL load Selector/Last with that index, clear the beat counter, and enter GRANT on the next edge.
REQ-015 Latency from Req sampled high in IDLE to Grant high SHALL be exactly 1 cycle.
REQ-016 Out_Data SHALL be the combinational selection of Data[Selector] at all times.
REQ-017 Out_Valid SHALL be combinational: high iff state==GRANT and Req[Selector]==1.
REQ-018 A beat SHALL transfer on each edge where Out_Valid && Out_Ready; the granted requester treats Grant[i] && Out_Ready as acceptance.
REQ-019 Each transfer SHALL increment a 4-bit beat counter; Out_Ready low SHALL hold the counter, the grant and Selector.
REQ-020 GRANT SHALL exit to IDLE on the next edge when either (a) a transfer occurs with counter == MAX_BURST-1, or (b) Req[Selector]==0. Burst_Done SHALL be high in that cycle.
REQ-021 If (a) and (b) both hold in a cycle, the transfer SHALL count and a single Burst_Done SHALL result.
REQ-022 IDLE SHALL last at least one cycle between grants; the requester just released has lowest priority at re-arbitration.
REQ-023 Changes to non-granted Req bits during GRANT SHALL have no effect until IDLE.

Reset
REQ-024 With reset high at an edge, the module SHALL set state=IDLE, Last=3, Selector=0, counter=0. Grant=0, Out_Valid=0 and Burst_Done=0 SHALL follow on the next cycle. Requester 0 SHALL be first in priority after reset.
REQ-025 Reset asserted mid-burst SHALL abandon the burst with no Burst_Done pulse; reset SHALL take priority over every other event.

Structure
REQ-026 The state encodings (IDLE=0, GRANT=1), NUM_REQ=4, and the counter width (4) SHALL live in a shared package/include used by the arbiter and its bench.
REQ-027 The data path SHALL be one instance of the existing Mux4to1, with WORD_LENGTH passed through and Selector driving its select. The FSM, pointer and counter SHALL stay in rr_mux_arbiter.

Verification
REQ-028 Reset, then Req=4'b0001, Out_Ready=1, MAX_BURST=4 -> Grant=0001 one cycle later; 4 beats of Data0 transferred; Burst_Done on beat 4; 1 IDLE cycle; re-grant to requester 0.
REQ-029 Req=4'b1111 held, Out_Ready=1 -> grants in order 0,1,2,3,0. Each grant lasts 4 beats with exactly one IDLE cycle between grants.
REQ-030 Requester 2 granted, Out_Ready toggling 1,0,1,0 -> counter advances only on ready cycles; Selector=2 stays stable; Out_Data=Data2 throughout.
REQ-031 Requester 1 granted, Req[1] dropped after 2 beats -> Out_Valid=0 that cycle; Burst_Done pulses; IDLE next; no third beat counted.
REQ-032 Reset asserted on beat 2 of a burst to requester 3 -> next cycle Grant=0, Out_Valid=0, no Burst_Done. With Req=1111, the next grant goes to requester 0.
REQ-033 MAX_BURST=1 with Req=4'b0101 -> grants alternate 0,2,0,2, one beat each.
